// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per clock, LSB first, with a
// registered result that updates only when the last bit has been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_s;
    logic             bit_c;
    logic             load;

    assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // The DONE cycle also accepts a new start so additions can issue every
    // WIDTH+1 cycles; without one it falls back to IDLE.
    assign load = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                psum_d  = {bit_s, psum_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {bit_s, psum_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = load ? ADD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
